fifo_rptr_empty: RTL

Read-domain pointer and empty-flag generator for the asynchronous FIFO. It advances the read pointer on accepted reads and drives the binary RAM read address. It publishes the Gray-coded read pointer for synchronization into the write domain. It compares its own pointer against the write pointer already synchronized into the read domain to produce registered empty, almost-empty, occupancy and underflow outputs.

---
 rtl/fifo_rptr_empty.sv | 72 +++++++
 1 files changed

// File: rtl/fifo_rptr_empty.sv
// Read-side pointer and flag generator for the async FIFO: owns the binary/Gray
// read pointer and derives registered empty, almost-empty, count and underflow.
module fifo_rptr_empty #(
   parameter int ADDR_WIDTH    = 4,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH:0]   rd_wptr_sync,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [ADDR_WIDTH:0]   rd_ptr_gray,
   output logic                  rd_empty,
   output logic                  rd_almost_empty,
   output logic [ADDR_WIDTH:0]   rd_count,
   output logic                  rd_underflow
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] AE_THRESH = PW'(AEMPTY_THRESH);

   logic [PW-1:0] rd_bin;
   logic [PW-1:0] bin_next;
   logic [PW-1:0] gray_next;
   logic [PW-1:0] wbin;
   logic [PW-1:0] count_next;
   logic          rd_inc;
   logic          empty_next;
   logic          aempty_next;

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // The next-pointer comparison (not the current one) makes the emptying read
   // raise rd_empty on the same edge it is accepted.
   always_comb begin
      rd_inc      = rd_en & ~rd_empty;
      bin_next    = rd_bin + {{ADDR_WIDTH{1'b0}}, rd_inc};
      gray_next   = (bin_next >> 1) ^ bin_next;
      wbin        = gray2bin(rd_wptr_sync);
      count_next  = wbin - bin_next;
      empty_next  = (gray_next == rd_wptr_sync);
      aempty_next = (count_next <= AE_THRESH);
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         rd_bin          <= '0;
         rd_ptr_gray     <= '0;
         rd_empty        <= 1'b1;
         rd_almost_empty <= 1'b1;
         rd_count        <= '0;
         rd_underflow    <= 1'b0;
      end else begin
         rd_bin          <= bin_next;
         rd_ptr_gray     <= gray_next;
         rd_empty        <= empty_next;
         rd_almost_empty <= aempty_next;
         rd_count        <= count_next;
         rd_underflow    <= rd_en & rd_empty;
      end
   end

   assign rd_addr = rd_bin[ADDR_WIDTH-1:0];

endmodule
